// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver: 16x-oversampled UART receive deserializer.
// Turns the asynchronous uart_rx line into 5..8 bit characters plus an
// optional parity bit. All bit timing advances only on tick pulses.
// Each completed frame gives a one-clock rx_valid strobe. The frame, parity
// and break strobes are aligned with rx_valid.
//
// Handshake: rx_valid is a one-clock strobe with no back-pressure. The
// consumer must take rx_data on the clock where rx_valid=1. rx_data then
// holds its value until the next rx_valid.
module uart_receiver #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [1:0] word_len,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       two_stop,
    input  logic       uart_rx,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       break_det,
    output logic       busy,
    output logic [2:0] state_out
);

    localparam int TW = $clog2(OVS);

    // Three samples are taken around the bit centre. The bit value is the
    // majority of the three, resolved at the third sample.
    localparam logic [TW-1:0] T_S0  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_RES = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] PARITY   = 3'd3;
    localparam logic [2:0] STOP1    = 3'd4;
    localparam logic [2:0] STOP2    = 3'd5;
    localparam logic [2:0] BRK_WAIT = 3'd6;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [2:0]             state;
    logic [TW-1:0]          tcnt;
    logic [2:0]             bcnt;
    logic [2:0]             last_bit;
    logic                   samp0;
    logic                   samp1;
    logic                   maj;
    logic [7:0]             data_sr;
    logic                   par_bit;
    logic                   stop1_bit;
    logic                   stops_ok;
    logic                   stops_zero;
    logic                   par_bad;

    // Metastability synchronizer. It resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign last_bit = {1'b0, word_len} + 3'd4;

    // Majority vote and the frame verdict used when the frame is finalised.
    // With one stop bit, the current majority is the only stop bit.
    always_comb begin
        maj        = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
        stops_ok   = (state == STOP2) ? (stop1_bit & maj) : maj;
        stops_zero = (state == STOP2) ? (!stop1_bit && !maj) : !maj;
        par_bad    = parity_en && ((^data_sr ^ par_bit) != parity_odd);
    end

    // Receive FSM, bit timing and output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tcnt       <= '0;
            bcnt       <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            data_sr    <= '0;
            par_bit    <= 1'b0;
            stop1_bit  <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            if (!enable) begin
                state <= IDLE;
            end else if (tick) begin
                if (tcnt == T_S0) samp0 <= rxs;
                if (tcnt == T_S1) samp1 <= rxs;
                if (state != IDLE && state != BRK_WAIT) tcnt <= tcnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state     <= START;
                            tcnt      <= '0;
                            bcnt      <= '0;
                            data_sr   <= '0;
                            par_bit   <= 1'b0;
                            stop1_bit <= 1'b1;
                        end
                    end
                    START: begin
                        if (tcnt == T_S0 && rxs) state <= IDLE;
                        else if (tcnt == T_END) state <= DATA;
                    end
                    DATA: begin
                        if (tcnt == T_RES) data_sr[bcnt] <= maj;
                        if (tcnt == T_END) begin
                            if (bcnt == last_bit) state <= parity_en ? PARITY : STOP1;
                            else bcnt <= bcnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        if (tcnt == T_RES) par_bit <= maj;
                        if (tcnt == T_END) state <= STOP1;
                    end
                    STOP1, STOP2: begin
                        if (tcnt == T_RES) begin
                            if (state == STOP1 && two_stop) begin
                                stop1_bit <= maj;
                            end else begin
                                rx_valid   <= 1'b1;
                                rx_data    <= {par_bit, data_sr};
                                frame_err  <= !stops_ok;
                                parity_err <= par_bad;
                                break_det  <= stops_zero && (data_sr == 8'd0) && !par_bit;
                                state      <= stops_ok ? IDLE : BRK_WAIT;
                            end
                        end else if (tcnt == T_END && state == STOP1) begin
                            state <= STOP2;
                        end
                    end
                    BRK_WAIT: begin
                        if (rxs) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Testbench for uart_receiver. Directed UART frames are driven one bit per
// 16 clocks with tick held high. Every frame pushes its expected result into
// exp_q. The monitor pops from exp_q on each rx_valid and compares.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       tick = 1'b1;
    logic [1:0] word_len = 2'd3;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       uart_rx = 1'b1;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       break_det;
    logic       busy;
    logic [2:0] state_out;

    uart_receiver #(.OVS(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tick       (tick),
        .word_len   (word_len),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .break_det  (break_det),
        .busy       (busy),
        .state_out  (state_out)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    // Each exp_q entry is {break_det, parity_err, frame_err, rx_data[8:0]}.
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    int tests = 0;
    int fails = 0;
    int n_valid = 0;
    int valid_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                n_valid++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got rx_data 0x%0h, required no strobe", rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", {23'd0, rx_data}, {23'd0, mon_e[8:0]});
                    check("frame_err", {31'd0, frame_err}, {31'd0, mon_e[9]});
                    check("parity_err", {31'd0, parity_err}, {31'd0, mon_e[10]});
                    check("break_det", {31'd0, break_det}, {31'd0, mon_e[11]});
                end
            end else if (frame_err || parity_err || break_det) begin
                tests++;
                fails++;
                $display("FAIL stray_strobe: got f=%0b p=%0b b=%0b without rx_valid, required 0",
                         frame_err, parity_err, break_det);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input logic s1, input logic ts, input logic s2);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(s1);
        if (ts) drive_bit(s2);
    endtask

    task automatic push(input logic brk, input logic perr, input logic ferr, input logic [8:0] d);
        exp_q.push_back({brk, perr, ferr, d});
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    int c0;
    int nv0;

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", {23'd0, rx_data}, 32'd0);
        check("reset_strobes", {28'd0, rx_valid, frame_err, parity_err, break_det}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_state", {29'd0, state_out}, 32'd0);
        reset = 1'b1;
        idle(20);

        // 1: 8N1 0x55, latency from the start edge
        push(1'b0, 1'b0, 1'b0, 9'h055);
        c0 = cyc;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("t1_drain");
        check("t1_latency_in_window", {31'd0, (valid_cyc - c0 >= 150) && (valid_cyc - c0 <= 162)}, 32'd1);
        check("t1_idle_after", {31'd0, busy}, 32'd0);
        idle(20);

        // 2: 7E1, 0x41 with wrong parity 1, then 0x43 with correct parity 1
        word_len = 2'd2; parity_en = 1'b1; parity_odd = 1'b0;
        push(1'b0, 1'b1, 1'b0, 9'h141);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 9'h143);
        send_frame(8'h43, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain("t2_drain");
        idle(20);

        // 3: start glitch, then a clean 0xA3
        word_len = 2'd3; parity_en = 1'b0;
        nv0 = n_valid;
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_busy_in_start", {29'd0, state_out}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("t3_false_start_idle", {29'd0, state_out}, 32'd0);
        check("t3_no_valid", n_valid, nv0);
        push(1'b0, 1'b0, 1'b0, 9'h0A3);
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("t3_drain");
        idle(20);

        // 4: break, line low for two frame times, then 0xFF
        push(1'b1, 1'b0, 1'b1, 9'h000);
        uart_rx = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("t4_brk_wait", {29'd0, state_out}, 32'd6);
        repeat (120) @(posedge clk);
        #1;
        check("t4_brk_wait_held", {29'd0, state_out}, 32'd6);
        wait_drain("t4_break_drain");
        idle(4);
        check("t4_idle_on_high", {29'd0, state_out}, 32'd0);
        idle(20);
        push(1'b0, 1'b0, 1'b0, 9'h0FF);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("t4_drain");
        idle(20);

        // 5: 5O2, 0x1F with the second stop bit 0, with both parity bit values
        word_len = 2'd0; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
        push(1'b0, 1'b1, 1'b1, 9'h11F);
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(20);
        push(1'b0, 1'b0, 1'b1, 9'h01F);
        send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("t5_left_brk_wait", {29'd0, state_out}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 9'h10A);
        send_frame(8'h0A, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_drain("t5_drain");
        idle(20);

        // 6: reset in the middle of a DATA bit, then back-to-back 0x00 and 0xFF
        word_len = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        uart_rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t6_busy_before_reset", {29'd0, state_out}, 32'd2);
        reset = 1'b0;
        #1;
        check("t6_reset_rx_data", {23'd0, rx_data}, 32'd0);
        check("t6_reset_state", {29'd0, state_out}, 32'd0);
        check("t6_reset_busy_valid", {30'd0, busy, rx_valid}, 32'd0);
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(20);
        nv0 = n_valid;
        push(1'b0, 1'b0, 1'b0, 9'h000);
        push(1'b0, 1'b0, 1'b0, 9'h0FF);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        wait_drain("t6_drain");
        check("t6_two_valids", n_valid - nv0, 32'd2);
        idle(20);

        // 7: enable dropped mid-frame discards the frame
        nv0 = n_valid;
        drive_bit(1'b0);
        drive_bit(1'b1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t7_disable_idle", {30'd0, busy, rx_valid}, 32'd0);
        idle(40);
        enable = 1'b1;
        idle(20);
        check("t7_no_valid", n_valid, nv0);
        push(1'b0, 1'b0, 1'b0, 9'h05A);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("t7_drain");
        idle(10);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
